// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that shares one SPI master among NUM_REQ requesters,
// issuing one transaction at a time and returning read data after a guard interval.
//
// state | meaning
// IDLE  | waiting for any req_valid; grants and latches the winner
// ISSUE | one-cycle length pulse to the master, guard counter loaded
// WAIT  | guard counter running down, master outputs held
// RESP  | one-cycle response pulse to the granted requester
module spi_txn_arbiter #(
  parameter int NUM_REQ               = 4,
  parameter int DATA_WIDTH            = 32,
  parameter int TRANSACTION_LEN_WIDTH = 6,
  parameter int GUARD_WIDTH           = 16
) (
  input  logic                                     fabric_clk,
  input  logic                                     reset_n,
  input  logic [NUM_REQ-1:0]                       req_valid,
  output logic [NUM_REQ-1:0]                       req_ready,
  input  logic [NUM_REQ*TRANSACTION_LEN_WIDTH-1:0] req_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]            req_data,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]            req_mask,
  input  logic [NUM_REQ-1:0]                       req_cpol,
  input  logic [NUM_REQ-1:0]                       req_cpha,
  input  logic [GUARD_WIDTH-1:0]                   guard_cycles,
  output logic [NUM_REQ-1:0]                       resp_valid,
  output logic [DATA_WIDTH-1:0]                    resp_data,
  output logic                                     resp_err,
  output logic                                     busy,
  output logic [TRANSACTION_LEN_WIDTH-1:0]         spi_transaction_length,
  output logic [DATA_WIDTH-1:0]                    spi_transaction_data,
  output logic [DATA_WIDTH-1:0]                    spi_transaction_rw_mask,
  output logic                                     spi_cpol,
  output logic                                     spi_cpha,
  input  logic [DATA_WIDTH-1:0]                    spi_transaction_read_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LW    = TRANSACTION_LEN_WIDTH;
  localparam int LWP   = LW + 1;
  localparam logic [LW:0] MAX_LEN = LWP'(DATA_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_nxt;
  logic [PTR_W-1:0]        grant_idx, lat_grant_q;
  logic                    grant_found;
  int                      idx_c;
  logic [LW-1:0]           sel_len, lat_len_q;
  logic                    sel_bad, lat_err_q;
  logic [DATA_WIDTH-1:0]   lat_data_q, lat_mask_q, resp_data_q, window;
  logic                    lat_cpol_q, lat_cpha_q, has_reads;
  logic [GUARD_WIDTH-1:0]  cnt_q, guard_load;

  // First requester at or after the pointer, wrapping.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    idx_c       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_c = int'(ptr_q) + k;
      if (idx_c >= NUM_REQ) idx_c = idx_c - NUM_REQ;
      if (!grant_found && req_valid[idx_c]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(idx_c);
      end
    end
  end

  assign sel_len    = req_len[int'(grant_idx)*LW +: LW];
  assign sel_bad    = (sel_len == '0) || ({1'b0, sel_len} > MAX_LEN);
  assign ptr_nxt    = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
  assign guard_load = (guard_cycles == '0) ? GUARD_WIDTH'(1) : guard_cycles;

  // Only the top len bits of the mask take part in the read test.
  assign window    = ~({DATA_WIDTH{1'b1}} >> lat_len_q);
  assign has_reads = |(window & ~lat_mask_q);

  assign spi_transaction_data    = lat_data_q;
  assign spi_transaction_rw_mask = lat_mask_q;
  assign spi_cpol                = lat_cpol_q;
  assign spi_cpha                = lat_cpha_q;

  always_comb begin
    state_d                = state_q;
    req_ready              = '0;
    resp_valid             = '0;
    resp_err               = 1'b0;
    resp_data              = '0;
    spi_transaction_length = '0;
    busy                   = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          state_d = sel_bad ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        spi_transaction_length = lat_len_q;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == GUARD_WIDTH'(1)) state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid[lat_grant_q] = 1'b1;
        resp_err  = lat_err_q;
        resp_data = resp_data_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      lat_grant_q <= '0;
      lat_len_q   <= '0;
      lat_data_q  <= '0;
      lat_mask_q  <= '0;
      lat_cpol_q  <= 1'b0;
      lat_cpha_q  <= 1'b0;
      lat_err_q   <= 1'b0;
      cnt_q       <= '0;
      resp_data_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (grant_found) begin
            lat_grant_q <= grant_idx;
            lat_len_q   <= sel_len;
            lat_data_q  <= req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            lat_mask_q  <= req_mask[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            lat_cpol_q  <= req_cpol[grant_idx];
            lat_cpha_q  <= req_cpha[grant_idx];
            lat_err_q   <= sel_bad;
            ptr_q       <= ptr_nxt;
            resp_data_q <= '0;
          end
        end
        ST_ISSUE: cnt_q <= guard_load;
        ST_WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (state_d == ST_RESP)
            resp_data_q <= has_reads ? spi_transaction_read_data : '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: a transaction-timeline model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_spi_txn_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 6;
  localparam int GW = 16;

  logic              fabric_clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_valid, req_ready, req_cpol, req_cpha, resp_valid;
  logic [N*LW-1:0]   req_len;
  logic [N*DW-1:0]   req_data, req_mask;
  logic [GW-1:0]     guard_cycles;
  logic [DW-1:0]     resp_data, spi_transaction_data, spi_transaction_rw_mask;
  logic [DW-1:0]     spi_transaction_read_data;
  logic              resp_err, busy, spi_cpol, spi_cpha;
  logic [LW-1:0]     spi_transaction_length;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  spi_txn_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TRANSACTION_LEN_WIDTH(LW), .GUARD_WIDTH(GW)) dut (
    .fabric_clk(fabric_clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
    .req_data(req_data), .req_mask(req_mask), .req_cpol(req_cpol), .req_cpha(req_cpha),
    .guard_cycles(guard_cycles), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy), .spi_transaction_length(spi_transaction_length),
    .spi_transaction_data(spi_transaction_data), .spi_transaction_rw_mask(spi_transaction_rw_mask),
    .spi_cpol(spi_cpol), .spi_cpha(spi_cpha), .spi_transaction_read_data(spi_transaction_read_data)
  );

  always #5 fabric_clk = ~fabric_clk;
  always @(posedge fabric_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: one transaction record with the cycles at which things must happen.
  int            m_ptr = 0;
  bit            m_act = 0;
  int            m_grant_cyc, m_issue_cyc, m_resp_cyc, m_g, m_len;
  bit            m_err, m_cpol, m_cpha;
  logic [DW-1:0] m_data, m_mask, m_prev_rd;

  int            obs_ready_cyc, obs_len_cyc, obs_len_val, obs_resp_cyc, len_pulses = 0;
  logic [N-1:0]  obs_resp_vec;
  logic [DW-1:0] obs_resp_data;
  logic          obs_resp_err;
  int            grant_log[$];

  always @(negedge fabric_clk) begin
    logic [N-1:0]  e_ready, e_resp;
    int            e_len;
    logic [DW-1:0] e_data;
    bit            hr;
    if (!reset_n) begin
      check("reset_ctrl", {req_ready, resp_valid, resp_err, busy, spi_transaction_length, spi_cpol, spi_cpha}, 0);
      check("reset_data", 64'(spi_transaction_data | spi_transaction_rw_mask | resp_data), 0);
      m_ptr = 0;
      m_act = 0;
    end else begin
      if (m_act && cyc > m_resp_cyc) m_act = 0;
      e_ready = '0;
      if (!m_act && req_valid != '0) begin
        m_g = -1;
        for (int k = 0; k < N; k++)
          if (m_g < 0 && req_valid[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
        e_ready[m_g] = 1'b1;
        m_len  = int'(req_len[m_g*LW +: LW]);
        m_data = req_data[m_g*DW +: DW];
        m_mask = req_mask[m_g*DW +: DW];
        m_cpol = req_cpol[m_g];
        m_cpha = req_cpha[m_g];
        m_err  = (m_len == 0) || (m_len > DW);
        m_grant_cyc = cyc;
        m_issue_cyc = m_err ? -1 : cyc + 1;
        m_resp_cyc  = m_err ? cyc + 1 : 32'h4000_0000;
        m_ptr = (m_g + 1) % N;
        m_act = 1;
      end
      if (m_act && cyc == m_issue_cyc)
        m_resp_cyc = cyc + ((guard_cycles == 0) ? 1 : int'(guard_cycles)) + 1;
      e_len  = (m_act && cyc == m_issue_cyc) ? m_len : 0;
      e_resp = '0;
      if (m_act && cyc == m_resp_cyc) e_resp[m_g] = 1'b1;
      check("req_ready", req_ready, e_ready);
      check("spi_len", spi_transaction_length, e_len);
      check("resp_valid", resp_valid, e_resp);
      check("busy", busy, m_act && cyc != m_grant_cyc);
      if (e_resp != '0) begin
        hr = 0;
        if (!m_err)
          for (int b = 0; b < m_len; b++) if (!m_mask[DW-1-b]) hr = 1;
        e_data = (!m_err && hr) ? m_prev_rd : '0;
        check("resp_data", resp_data, e_data);
        check("resp_err", resp_err, m_err);
      end
      if (m_act && !m_err && cyc >= m_issue_cyc && cyc < m_resp_cyc) begin
        check("spi_data", spi_transaction_data, m_data);
        check("spi_mask", spi_transaction_rw_mask, m_mask);
        check("spi_mode", {spi_cpol, spi_cpha}, {m_cpol, m_cpha});
      end
      if (req_ready != '0) begin
        obs_ready_cyc = cyc;
        for (int k = 0; k < N; k++) if (req_ready[k]) grant_log.push_back(k);
      end
      if (spi_transaction_length != '0) begin
        obs_len_cyc = cyc;
        obs_len_val = int'(spi_transaction_length);
        len_pulses++;
      end
      if (resp_valid != '0) begin
        obs_resp_cyc  = cyc;
        obs_resp_vec  = resp_valid;
        obs_resp_data = resp_data;
        obs_resp_err  = resp_err;
      end
    end
    m_prev_rd = spi_transaction_read_data;
  end

  task automatic send(input int idx, input int len, input logic [DW-1:0] data, input logic [DW-1:0] mask,
                      input bit cpol, input bit cpha, output int t);
    req_len[idx*LW +: LW] = LW'(len);
    req_data[idx*DW +: DW] = data;
    req_mask[idx*DW +: DW] = mask;
    req_cpol[idx] = cpol;
    req_cpha[idx] = cpha;
    req_valid[idx] = 1'b1;
    t = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge fabric_clk);
      if (req_ready[idx]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL req_ready_timeout: requester %0d got no req_ready, required within 300 cycles", idx);
    end
    @(posedge fabric_clk);
    #1 req_valid[idx] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge fabric_clk);
      if (!busy) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: busy still high, required low within 300 cycles");
    end
    @(posedge fabric_clk);
    #1;
  endtask

  initial begin
    int t, lp0, n;
    int rc[5];
    reset_n = 1'b0;
    req_valid = '0; req_len = '0; req_data = '0; req_mask = '0;
    req_cpol = '0; req_cpha = '0; guard_cycles = '0; spi_transaction_read_data = '0;
    repeat (3) @(posedge fabric_clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_len", spi_transaction_length, 0);
    check("rst_resp", resp_valid, 0);
    reset_n = 1'b1;
    @(posedge fabric_clk);
    #1;

    // single write; read data present but must not be returned
    guard_cycles = 16'd20;
    spi_transaction_read_data = 32'hDEAD_BEEF;
    lp0 = len_pulses;
    send(0, 8, 32'hA500_0000, 32'hFF00_0000, 1'b0, 1'b0, t);
    wait_idle();
    check("t1_len_cyc", obs_len_cyc, t + 1);
    check("t1_len_val", obs_len_val, 8);
    check("t1_len_pulses", len_pulses - lp0, 1);
    check("t1_resp_cyc", obs_resp_cyc, t + 22);
    check("t1_model_resp_cyc", m_resp_cyc, t + 22);
    check("t1_resp_vec", obs_resp_vec, 4'b0001);
    check("t1_resp_data", obs_resp_data, 0);
    check("t1_resp_err", obs_resp_err, 0);

    // mixed read
    guard_cycles = 16'd40;
    spi_transaction_read_data = 32'h0000_00C3;
    send(1, 16, 32'h1234_0000, 32'hFF00_0000, 1'b1, 1'b0, t);
    wait_idle();
    check("t2_resp_cyc", obs_resp_cyc, t + 42);
    check("t2_resp_vec", obs_resp_vec, 4'b0010);
    check("t2_resp_data", obs_resp_data, 32'h0000_00C3);
    check("t2_resp_err", obs_resp_err, 0);

    // invalid lengths
    lp0 = len_pulses;
    send(2, 0, 32'h5555_5555, 32'h0, 1'b0, 1'b1, t);
    wait_idle();
    check("t3a_resp_cyc", obs_resp_cyc, t + 1);
    check("t3a_resp_vec", obs_resp_vec, 4'b0100);
    check("t3a_resp_err", obs_resp_err, 1);
    check("t3a_resp_data", obs_resp_data, 0);
    send(3, 33, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, t);
    wait_idle();
    check("t3b_resp_cyc", obs_resp_cyc, t + 1);
    check("t3b_resp_vec", obs_resp_vec, 4'b1000);
    check("t3b_resp_err", obs_resp_err, 1);
    check("t3b_resp_data", obs_resp_data, 0);
    check("t3_no_len_pulse", len_pulses - lp0, 0);

    // round-robin with all requesters held valid, pointer now at 0
    guard_cycles = 16'd2;
    spi_transaction_read_data = 32'h1357_2468;
    req_len  = {6'd32, 6'd12, 6'd8, 6'd4};
    req_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0F00_0000};
    req_mask = {32'hFFFF_FFFE, 32'hFFF0_0000, 32'h0000_0000, 32'hF000_0000};
    req_cpol = 4'b0101;
    req_cpha = 4'b0011;
    grant_log.delete();
    lp0 = len_pulses;
    req_valid = 4'hF;
    n = 0;
    for (int i = 0; i < 200 && n < 5; i++) begin
      @(negedge fabric_clk);
      if (req_ready != '0) begin
        rc[n] = cyc;
        n++;
      end
    end
    @(posedge fabric_clk);
    #1 req_valid = '0;
    wait_idle();
    check("rr_grants", grant_log.size(), 5);
    check("rr_g0", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    check("rr_g1", grant_log.size() > 1 ? grant_log[1] : -1, 1);
    check("rr_g2", grant_log.size() > 2 ? grant_log[2] : -1, 2);
    check("rr_g3", grant_log.size() > 3 ? grant_log[3] : -1, 3);
    check("rr_g4", grant_log.size() > 4 ? grant_log[4] : -1, 0);
    check("rr_len_pulses", len_pulses - lp0, 5);
    check("rr_spacing", rc[4] - rc[0], 20);

    // guard zero behaves as one; full-width length is valid
    guard_cycles = 16'd0;
    spi_transaction_read_data = 32'h5A5A_5A5A;
    send(1, 32, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, t);
    wait_idle();
    check("g0_len_cyc", obs_len_cyc, t + 1);
    check("g0_len_val", obs_len_val, 32);
    check("g0_resp_cyc", obs_resp_cyc, obs_len_cyc + 2);
    check("g0_resp_data", obs_resp_data, 32'h5A5A_5A5A);

    // reset in the middle of WAIT
    guard_cycles = 16'd30;
    spi_transaction_read_data = 32'h0F0F_0F0F;
    send(2, 8, 32'h8800_0000, 32'h0, 1'b1, 1'b1, t);
    repeat (5) @(posedge fabric_clk);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_len", spi_transaction_length, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", spi_transaction_data, 0);
    check("mid_rst_mask", spi_transaction_rw_mask, 0);
    check("mid_rst_mode", {spi_cpol, spi_cpha}, 0);
    check("mid_rst_resp", resp_valid, 0);
    repeat (2) @(posedge fabric_clk);
    #1 reset_n = 1'b1;
    req_len[1*LW +: LW] = 6'd8;
    req_data[1*DW +: DW] = 32'h1100_0000;
    req_mask[1*DW +: DW] = 32'hFF00_0000;
    req_len[3*LW +: LW] = 6'd4;
    req_data[3*DW +: DW] = 32'h3000_0000;
    req_mask[3*DW +: DW] = 32'h0;
    req_valid = 4'b1010;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge fabric_clk);
      if (req_ready != '0) begin
        n = 1;
        break;
      end
    end
    check("post_rst_grant", req_ready, 4'b0010);
    @(posedge fabric_clk);
    #1 req_valid[1] = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge fabric_clk);
      if (req_ready[3]) break;
    end
    @(posedge fabric_clk);
    #1 req_valid = '0;
    wait_idle();
    check("post_rst_last_resp", obs_resp_vec, 4'b1000);
    check("post_rst_last_data", obs_resp_data, 32'h0F0F_0F0F);

    repeat (3) @(posedge fabric_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
